// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
//
// Instruction fetch stage. It issues word reads to a synchronous instruction
// memory, captures each returned word one cycle after the request, and
// buffers it in a 2-entry in-order FIFO. The head of the FIFO is presented
// to decode from registers.
//
// A fetched word of all zeros stops the stage (HALT). Only a redirect
// restarts fetching. Words already buffered still drain to decode.
//
// Ports:
//   clk            in   clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   imem_adr       out  byte address presented to instruction memory
//   imem_load      out  memory write enable (always 0)
//   imem_in        out  memory write data (always 0)
//   imem_out       in   memory read data, valid the cycle after the request
//   imem_done      in   memory ready; requests issue only while high
//   redirect_valid in   branch/jump redirect strobe
//   redirect_pc    in   redirect target (low two bits ignored)
//   if_valid       out  instruction available to decode
//   if_pc          out  byte address of the presented instruction
//   if_instr       out  presented instruction word
//   id_ready       in   decode accepts the presented instruction
// ---------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_adr,
  output logic        imem_load,
  output logic [31:0] imem_in,
  input  logic [31:0] imem_out,
  input  logic        imem_done,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        id_ready
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] LAST_PC = 32'(MEM_SIZE * 4 - 4);

  state_t      state;
  logic        inflight;
  logic [31:0] inflight_pc;

  // Second FIFO slot. The head slot is the if_valid/if_pc/if_instr registers.
  logic        v1;
  logic [31:0] pc1;
  logic [31:0] instr1;

  logic [1:0]  count;
  logic [1:0]  reserve;
  logic        pop;
  logic        issue;
  logic        capture;
  logic        push;
  logic        halt_hit;
  logic [31:0] next_pc;

  logic        h_v;
  logic [31:0] h_pc;
  logic [31:0] h_instr;
  logic        t_v;
  logic [31:0] t_pc;
  logic [31:0] t_instr;

  assign imem_load = 1'b0;
  assign imem_in   = 32'h0;

  assign count   = {1'b0, if_valid} + {1'b0, v1};
  assign pop     = if_valid & id_ready;
  // The issue rule counts the word still in flight, so the FIFO always has a
  // free slot for every word that returns.
  assign reserve = count + {1'b0, inflight} - {1'b0, pop};
  assign issue   = (state == RUN) && imem_done && (reserve < 2'd2) && !redirect_valid;

  // Words returning after a halt belong to the path past the halt point and
  // are dropped. A redirect squashes the word returning in the same cycle.
  assign capture  = inflight && (state == RUN) && !redirect_valid;
  assign push     = capture && (imem_out != 32'h0);
  assign halt_hit = capture && (imem_out == 32'h0);

  assign next_pc = (imem_adr >= LAST_PC) ? 32'h0 : imem_adr + 32'd4;

  // Next FIFO contents: retire the head on a transfer, shift the tail up,
  // then place a newly captured word in the first free slot. A redirect
  // empties both slots after the transfer has completed.
  always_comb begin
    h_v     = if_valid;
    h_pc    = if_pc;
    h_instr = if_instr;
    t_v     = v1;
    t_pc    = pc1;
    t_instr = instr1;
    if (pop) begin
      h_v = v1;
      if (v1) begin
        h_pc    = pc1;
        h_instr = instr1;
      end
      t_v = 1'b0;
    end
    if (redirect_valid) begin
      h_v = 1'b0;
      t_v = 1'b0;
    end else if (push) begin
      if (!h_v) begin
        h_v     = 1'b1;
        h_pc    = inflight_pc;
        h_instr = imem_out;
      end else begin
        t_v     = 1'b1;
        t_pc    = inflight_pc;
        t_instr = imem_out;
      end
    end
  end

  // Fetch control FSM. imem_adr doubles as the fetch PC: it always holds the
  // address of the request that may issue in the current cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RUN;
      imem_adr    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 32'h0;
      if_valid    <= 1'b0;
      if_pc       <= 32'h0;
      if_instr    <= 32'h0;
      v1          <= 1'b0;
      pc1         <= 32'h0;
      instr1      <= 32'h0;
    end else begin
      if_valid <= h_v;
      if_pc    <= h_pc;
      if_instr <= h_instr;
      v1       <= t_v;
      pc1      <= t_pc;
      instr1   <= t_instr;
      if (redirect_valid) begin
        state    <= RUN;
        imem_adr <= {redirect_pc[31:2], 2'b00};
        inflight <= 1'b0;
      end else begin
        inflight <= issue;
        if (issue) begin
          inflight_pc <= imem_adr;
          imem_adr    <= next_pc;
        end
        if (halt_hit) begin
          state <= HALT;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed bench for instr_fetch. A synchronous 1024-word memory model
// returns mem[imem_adr] one cycle after each clock edge. Each task drives
// one scenario and compares outputs against hand-computed values.
// Cycle 0 is the first cycle with rst_n high. Outputs are sampled 1 ns
// after the rising edge that opens each cycle.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

  logic        clk;
  logic        rst_n;
  logic [31:0] imem_adr;
  logic        imem_load;
  logic [31:0] imem_in;
  logic [31:0] imem_out;
  logic        imem_done;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        id_ready;

  logic [31:0] mem [0:1023];
  int vectors;
  int miscompares;

  instr_fetch #(.RESET_PC(32'h0), .MEM_SIZE(1024)) dut (
    .clk(clk), .rst_n(rst_n), .imem_adr(imem_adr), .imem_load(imem_load),
    .imem_in(imem_in), .imem_out(imem_out), .imem_done(imem_done),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .id_ready(id_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read instruction memory.
  always @(posedge clk) imem_out <= mem[imem_adr[11:2]];

  // Guard against any hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_prog;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0000_0093;
    mem[2]    = 32'h0000_0113;
    mem[16]   = 32'h0400_0013;
    mem[17]   = 32'h0440_0093;
    mem[1023] = 32'h0000_0513;
  endtask

  // Leaves the bench 1 ns into cycle 0.
  task automatic do_reset;
    rst_n = 1'b0;
    id_ready = 1'b1;
    imem_done = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    id_ready = 1'b1;
    imem_done = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    imem_out = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_if_valid: got %b want 0", if_valid); end
    vectors++; if (if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_pc: got %h want 00000000", if_pc); end
    vectors++; if (if_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_if_instr: got %h want 00000000", if_instr); end
    vectors++; if (imem_adr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_imem_adr: got %h want 00000000", imem_adr); end
    vectors++; if (imem_load !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_imem_load: got %b want 0", imem_load); end
    vectors++; if (imem_in !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_imem_in: got %h want 00000000", imem_in); end
  endtask

  // Straight-line program ending in a zero word, decode always ready.
  // Requests issue in cycles 0..4, so imem_adr freezes at 0x14 once halted.
  task automatic test_stream;
    do_reset();
    vectors++; if (imem_adr !== 32'h0) begin miscompares++; $display("[TB] FAIL stream_adr_c0: got %h want 00000000", imem_adr); end
    tick();
    vectors++; if (imem_adr !== 32'h4) begin miscompares++; $display("[TB] FAIL stream_adr_c1: got %h want 00000004", imem_adr); end
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stream_valid_c1: got %b want 0", if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin miscompares++; $display("[TB] FAIL stream_c2: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=00000013", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h93) begin miscompares++; $display("[TB] FAIL stream_c3: got v=%b pc=%h instr=%h want v=1 pc=00000004 instr=00000093", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h113) begin miscompares++; $display("[TB] FAIL stream_c4: got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=00000113", if_valid, if_pc, if_instr); end
    for (int c = 5; c <= 8; c++) begin
      tick();
      vectors++; if (if_valid !== 1'b0 || imem_adr !== 32'h14) begin miscompares++; $display("[TB] FAIL stream_halt_c%0d: got v=%b adr=%h want v=0 adr=00000014", c, if_valid, imem_adr); end
    end
  endtask

  // Continues from the halted state left by test_stream (cycle 8).
  task automatic test_halt_redirect;
    redirect_valid = 1'b1;
    redirect_pc = 32'h7;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (imem_adr !== 32'h4 || if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_redir_issue: got adr=%h v=%b want adr=00000004 v=0", imem_adr, if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL halt_redir_wait: got v=%b want 0", if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h93) begin miscompares++; $display("[TB] FAIL halt_redir_first: got v=%b pc=%h instr=%h want v=1 pc=00000004 instr=00000093", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin miscompares++; $display("[TB] FAIL halt_redir_second: got v=%b pc=%h want v=1 pc=00000008", if_valid, if_pc); end
  endtask

  // Decode stalls for cycles 2..6; the FIFO fills to 2 and issue stops.
  task automatic test_stall;
    do_reset();
    tick();
    tick();
    id_ready = 1'b0;
    for (int c = 2; c <= 6; c++) begin
      vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin miscompares++; $display("[TB] FAIL stall_hold_c%0d: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=00000013", c, if_valid, if_pc, if_instr); end
      if (c != 6) tick();
    end
    vectors++; if (imem_adr !== 32'h8) begin miscompares++; $display("[TB] FAIL stall_no_issue: got adr=%h want 00000008", imem_adr); end
    tick();
    id_ready = 1'b1;
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL stall_c7: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h93) begin miscompares++; $display("[TB] FAIL stall_c8: got v=%b pc=%h instr=%h want v=1 pc=00000004 instr=00000093", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h113) begin miscompares++; $display("[TB] FAIL stall_c9: got v=%b pc=%h instr=%h want v=1 pc=00000008 instr=00000113", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_c10: got v=%b want 0", if_valid); end
  endtask

  // Redirect in cycle 3 while pc 4 is at the head and pc 8 is in flight.
  task automatic test_redirect;
    do_reset();
    tick();
    tick();
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin miscompares++; $display("[TB] FAIL redir_pre: got v=%b pc=%h want v=1 pc=00000004", if_valid, if_pc); end
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (if_valid !== 1'b0 || imem_adr !== 32'h40) begin miscompares++; $display("[TB] FAIL redir_c4: got v=%b adr=%h want v=0 adr=00000040", if_valid, imem_adr); end
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_c5: got v=%b want 0", if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_instr !== 32'h0400_0013) begin miscompares++; $display("[TB] FAIL redir_c6: got v=%b pc=%h instr=%h want v=1 pc=00000040 instr=04000013", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h44 || if_instr !== 32'h0440_0093) begin miscompares++; $display("[TB] FAIL redir_c7: got v=%b pc=%h instr=%h want v=1 pc=00000044 instr=04400093", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL redir_c8: got v=%b want 0", if_valid); end
  endtask

  // Reset pulsed in cycle 4 of streaming, then the sequence restarts.
  task automatic test_reset_mid;
    do_reset();
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    vectors++; if (if_valid !== 1'b0 || if_pc !== 32'h0 || if_instr !== 32'h0 || imem_adr !== 32'h0) begin miscompares++; $display("[TB] FAIL rstmid_clear: got v=%b pc=%h instr=%h adr=%h want all zero", if_valid, if_pc, if_instr, imem_adr); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rstmid_c1: got v=%b want 0", if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin miscompares++; $display("[TB] FAIL rstmid_c2: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=00000013", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4) begin miscompares++; $display("[TB] FAIL rstmid_c3: got v=%b pc=%h want v=1 pc=00000004", if_valid, if_pc); end
  endtask

  // Memory not ready in cycles 1..3.
  task automatic test_done_gap;
    do_reset();
    tick();
    imem_done = 1'b0;
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0) begin miscompares++; $display("[TB] FAIL gap_c2: got v=%b pc=%h want v=1 pc=00000000", if_valid, if_pc); end
    tick();
    vectors++; if (if_valid !== 1'b0 || imem_adr !== 32'h4) begin miscompares++; $display("[TB] FAIL gap_c3: got v=%b adr=%h want v=0 adr=00000004", if_valid, imem_adr); end
    tick();
    imem_done = 1'b1;
    vectors++; if (if_valid !== 1'b0 || imem_adr !== 32'h4) begin miscompares++; $display("[TB] FAIL gap_c4: got v=%b adr=%h want v=0 adr=00000004", if_valid, imem_adr); end
    tick();
    vectors++; if (if_valid !== 1'b0 || imem_adr !== 32'h8) begin miscompares++; $display("[TB] FAIL gap_c5: got v=%b adr=%h want v=0 adr=00000008", if_valid, imem_adr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h4 || if_instr !== 32'h93) begin miscompares++; $display("[TB] FAIL gap_c6: got v=%b pc=%h instr=%h want v=1 pc=00000004 instr=00000093", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h8) begin miscompares++; $display("[TB] FAIL gap_c7: got v=%b pc=%h want v=1 pc=00000008", if_valid, if_pc); end
    tick();
    vectors++; if (if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_c8: got v=%b want 0", if_valid); end
  endtask

  // Redirect to the last word of memory; the next fetch wraps to 0.
  task automatic test_wrap;
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFC;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (imem_adr !== 32'hFFC) begin miscompares++; $display("[TB] FAIL wrap_c1: got adr=%h want 00000ffc", imem_adr); end
    tick();
    vectors++; if (imem_adr !== 32'h0 || if_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL wrap_c2: got adr=%h v=%b want adr=00000000 v=0", imem_adr, if_valid); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'hFFC || if_instr !== 32'h513) begin miscompares++; $display("[TB] FAIL wrap_c3: got v=%b pc=%h instr=%h want v=1 pc=00000ffc instr=00000513", if_valid, if_pc, if_instr); end
    tick();
    vectors++; if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_instr !== 32'h13) begin miscompares++; $display("[TB] FAIL wrap_c4: got v=%b pc=%h instr=%h want v=1 pc=00000000 instr=00000013", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    load_prog();
    test_reset();
    test_stream();
    test_halt_redirect();
    test_stall();
    test_redirect();
    test_reset_mid();
    test_done_gap();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
